// File: rtl/dec_tlu_trigger_csr_pkg.sv
// rtl/dec_tlu_trigger_csr_pkg.sv - trigger CSR addresses, mcontrol bit positions and trigger packet type
package swerv_types;

  localparam logic [11:0] TSELECT = 12'h7A0;
  localparam logic [11:0] TDATA1  = 12'h7A1;
  localparam logic [11:0] TDATA2  = 12'h7A2;

  localparam logic [3:0] MC_TYPE_VAL = 4'h2;

  localparam int MC_TYPE_LSB   = 60;
  localparam int MC_DMODE      = 59;
  localparam int MC_HIT        = 20;
  localparam int MC_SELECT     = 19;
  localparam int MC_ACTION_LSB = 12;
  localparam int MC_CHAIN      = 11;
  localparam int MC_MATCH_LSB  = 7;
  localparam int MC_M          = 6;
  localparam int MC_EXECUTE    = 2;
  localparam int MC_STORE      = 1;
  localparam int MC_LOAD       = 0;

  typedef struct packed {
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic        execute;
    logic        m;
    logic [63:0] tdata2;
  } trigger_pkt_t;

endpackage

// File: rtl/dec_tlu_trigger_slot.sv
// rtl/dec_tlu_trigger_slot.sv - one trigger's tdata1/tdata2 state with dmode lock and sticky hit merge
module dec_tlu_trigger_slot
  import swerv_types::*;
#(
  parameter bit CHAIN_EN = 1'b0
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         wr_tdata1,
  input  logic         wr_tdata2,
  input  logic [63:0]  wrdata,
  input  logic         dec_tlu_debug_mode,
  input  logic         hit_set,
  output trigger_pkt_t pkt,
  output logic         chain,
  output logic [63:0]  tdata1
);

  logic        dmode, hit, select, match, m, execute, store, load, chain_q;
  logic [63:0] tdata2;
  logic        locked, wr1, wr2;

  // A debugger-owned trigger cannot be touched from machine mode at all.
  assign locked = dmode & ~dec_tlu_debug_mode;
  assign wr1    = wr_tdata1 & ~locked;
  assign wr2    = wr_tdata2 & ~locked;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      dmode   <= 1'b0;
      hit     <= 1'b0;
      select  <= 1'b0;
      match   <= 1'b0;
      m       <= 1'b0;
      execute <= 1'b0;
      store   <= 1'b0;
      load    <= 1'b0;
      chain_q <= 1'b0;
      tdata2  <= '0;
    end else begin
      if (wr1) begin
        dmode   <= wrdata[MC_DMODE] & dec_tlu_debug_mode;
        hit     <= wrdata[MC_HIT] | hit_set;
        select  <= wrdata[MC_SELECT];
        match   <= wrdata[MC_MATCH_LSB];
        m       <= wrdata[MC_M];
        execute <= wrdata[MC_EXECUTE];
        store   <= wrdata[MC_STORE];
        load    <= wrdata[MC_LOAD];
        chain_q <= CHAIN_EN & wrdata[MC_CHAIN];
      end else if (hit_set) begin
        hit <= 1'b1;
      end
      if (wr2) tdata2 <= wrdata;
    end
  end

  always_comb begin
    tdata1                                  = '0;
    tdata1[MC_TYPE_LSB+3:MC_TYPE_LSB]       = MC_TYPE_VAL;
    tdata1[MC_DMODE]                        = dmode;
    tdata1[MC_HIT]                          = hit;
    tdata1[MC_SELECT]                       = select;
    tdata1[MC_ACTION_LSB]                   = dmode;
    tdata1[MC_CHAIN]                        = chain_q;
    tdata1[MC_MATCH_LSB]                    = match;
    tdata1[MC_M]                            = m;
    tdata1[MC_EXECUTE]                      = execute;
    tdata1[MC_STORE]                        = store;
    tdata1[MC_LOAD]                         = load;
  end

  assign pkt.select  = select;
  assign pkt.match   = match;
  assign pkt.store   = store;
  assign pkt.load    = load;
  assign pkt.execute = execute;
  assign pkt.m       = m;
  assign pkt.tdata2  = tdata2;
  assign chain       = chain_q;

endmodule

// File: rtl/dec_tlu_trigger_csr.sv
// rtl/dec_tlu_trigger_csr.sv - tselect register, trigger CSR decode, write steering and readback mux
module dec_tlu_trigger_csr
  import swerv_types::*;
#(
  parameter int NUM_TRIG = 4
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic                        dec_csr_wen,
  input  logic [11:0]                 dec_csr_waddr,
  input  logic [63:0]                 dec_csr_wrdata,
  input  logic [11:0]                 dec_csr_raddr,
  input  logic                        dec_tlu_debug_mode,
  input  logic [NUM_TRIG-1:0]         trigger_hit_set,
  output trigger_pkt_t [NUM_TRIG-1:0] trigger_pkt_any,
  output logic [1:0]                  trigger_chain,
  output logic [63:0]                 trig_csr_rddata,
  output logic                        trig_csr_rdhit
);

  logic [1:0]          tselect;
  logic [NUM_TRIG-1:0] sel, wr_tdata1, wr_tdata2, chain_vec;
  logic [63:0]         td1 [NUM_TRIG];
  logic                unused_chain;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      tselect <= 2'd0;
    end else if (dec_csr_wen && dec_csr_waddr == TSELECT) begin
      tselect <= dec_csr_wrdata[1:0];
    end
  end

  always_comb begin
    sel          = '0;
    sel[tselect] = 1'b1;
  end

  assign wr_tdata1 = sel & {NUM_TRIG{dec_csr_wen && dec_csr_waddr == TDATA1}};
  assign wr_tdata2 = sel & {NUM_TRIG{dec_csr_wen && dec_csr_waddr == TDATA2}};

  for (genvar i = 0; i < NUM_TRIG; i++) begin : g_slot
    dec_tlu_trigger_slot #(
      .CHAIN_EN((i % 2) == 0)
    ) u_slot (
      .clk               (clk),
      .rst_l             (rst_l),
      .wr_tdata1         (wr_tdata1[i]),
      .wr_tdata2         (wr_tdata2[i]),
      .wrdata            (dec_csr_wrdata),
      .dec_tlu_debug_mode(dec_tlu_debug_mode),
      .hit_set           (trigger_hit_set[i]),
      .pkt               (trigger_pkt_any[i]),
      .chain             (chain_vec[i]),
      .tdata1            (td1[i])
    );
  end

  // Odd slots are built without chain support, so their chain outputs are always zero.
  assign trigger_chain = {chain_vec[2], chain_vec[0]};
  assign unused_chain  = chain_vec[1] ^ chain_vec[3];

  always_comb begin
    trig_csr_rddata = '0;
    trig_csr_rdhit  = 1'b1;
    case (dec_csr_raddr)
      TSELECT: trig_csr_rddata = {62'd0, tselect};
      TDATA1:  trig_csr_rddata = td1[tselect];
      TDATA2:  trig_csr_rddata = trigger_pkt_any[tselect].tdata2;
      default: trig_csr_rdhit  = 1'b0;
    endcase
  end

endmodule
